spi_input_conditioner: RTL and testbench
========================================

// Module: spi_input_conditioner
// PURPOSE
//  Front end of the SPI slave: synchronises the raw SCLK, CS and MOSI pins into the
//  system clock domain, debounces each, and emits single-cycle rising/falling edge
//  pulses. pos_edge[0] (SCLK rise) drives the transaction FSM's sclk_edge input.
//  conditioned[1] feeds its cs input. conditioned[2] (MOSI) feeds the shift register.
// PARAMETERS
//  WIDTH          3       channel count; bit0=SCLK, bit1=CS, bit2=MOSI
//  WAIT_TIME      3       extra stable cycles required before a change is accepted
//  COUNTER_WIDTH  3       debounce counter width; WAIT_TIME < 2**COUNTER_WIDTH required
//  RESET_VAL      3'b010  per-channel reset/idle level (CS idles high)
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  pins_in      in   WIDTH  raw asynchronous pin levels
//  conditioned  out  WIDTH  synchronised, debounced levels
//  pos_edge     out  WIDTH  1-cycle pulse, conditioned bit went 0->1
//  neg_edge     out  WIDTH  1-cycle pulse, conditioned bit went 1->0
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): sync1, sync2 and conditioned = RESET_VAL.
//    pos_edge = neg_edge = 0. All counters = 0. Held while rst_n=0.
//  - Each channel is independent (generate loop). The per-channel pipeline is:
//    sync1 <= pins_in[i]; sync2 <= sync1. Two-flop synchroniser.
//    sync2 is the only value compared; pins_in is never used combinationally.
//  - Debounce, every edge, per channel:
//    * sync2 == conditioned: counter <= 0; no pulse.
//    * sync2 != conditioned and counter == WAIT_TIME: conditioned <= sync2;
//      counter <= 0; pos_edge <= sync2; neg_edge <= ~sync2.
//    * sync2 != conditioned otherwise: counter <= counter + 1.
//  - pos_edge/neg_edge are registered. Each is high exactly one cycle, in the cycle
//    conditioned shows the new value. They are never both high on one channel.
//    They default to 0 every cycle they are not set.
//  - Latency: a pin change captured by sync1 at edge 0 appears on conditioned and
//    the edge pulse after edge WAIT_TIME+2 (WAIT_TIME=3: 5 clk).
//    WAIT_TIME=0 gives 2 clk.
//  - Glitch rejection: if sync2 returns to conditioned before the counter reaches
//    WAIT_TIME, the counter clears to 0, conditioned is unchanged, and no pulse fires.
//  - A bounce mid-count (differs, matches, differs) restarts the count from 0.
//  - The counter never exceeds WAIT_TIME, so no wrap-around is possible.
//  - Simultaneous changes on several channels pulse in the same cycle if their
//    stability windows coincide. There is no cross-channel ordering or priority.
//  - Reset mid-debounce aborts the count. No pulse is generated by reset or by
//    reset release.
//  - After release, a pin differing from RESET_VAL goes through the normal debounce
//    and then pulses once.
//  - Input toggling continuously faster than WAIT_TIME+1 clk yields no pulses.
//    Conditioned holds its last value.
// TESTING
//  1. Reset: rst_n=0 with pins_in=3'b101. Outputs must be conditioned=3'b010,
//     pos_edge=0 and neg_edge=0, asynchronously and with no clk edge.
//  2. Clean SCLK rise (WAIT_TIME=3): pins_in[0] 0->1 before edge 0.
//     Required: conditioned[0]=1 and pos_edge=3'b001 after edge 5, for 1 cycle only.
//  3. Glitch: pins_in[0] high for 2 clk, then low.
//     Required: conditioned[0] stays 0; pos_edge and neg_edge stay 0 throughout.
//  4. CS fall with MOSI rise on the same clk: pins_in 3'b010->3'b101.
//     Required: one cycle of neg_edge=3'b010 and pos_edge=3'b101 (SCLK rises too);
//     conditioned=3'b101.
//  5. Reset mid-count: drop rst_n at counter=2 during a MOSI rise, then release.
//     Required: no pulse during reset; pos_edge[2] pulses 5 clk after the first
//     post-release capture.
//  6. Bounce: pins_in[1] 1->0 for 3 clk, 1 for 1 clk, 0 held.
//     Required: a single neg_edge[1] pulse, 5 clk after the final 1->0 capture.

Source files
------------

// File: rtl/spi_input_conditioner_if.sv
// Pin/condition bundle between the raw SPI pads and the SPI slave front end.
// master = pad/stimulus side, slave = conditioner side.
interface spi_input_conditioner_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] pins_in;
  logic [WIDTH-1:0] conditioned;
  logic [WIDTH-1:0] pos_edge;
  logic [WIDTH-1:0] neg_edge;

  modport master (
    output pins_in,
    input  conditioned,
    input  pos_edge,
    input  neg_edge
  );

  modport slave (
    input  pins_in,
    output conditioned,
    output pos_edge,
    output neg_edge
  );
endinterface

// File: rtl/spi_input_conditioner.sv
// SPI pin front end: per-channel 2-flop synchroniser, stability-window debounce
// and registered single-cycle rise/fall pulses. bit0=SCLK, bit1=CS, bit2=MOSI.
module spi_ic_lane #(
  parameter int   WAIT_TIME     = 3,
  parameter int   COUNTER_WIDTH = 3,
  parameter logic RST_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_in,
  output logic cond,
  output logic pos,
  output logic neg
);
  localparam logic [COUNTER_WIDTH-1:0] WAIT_CNT = COUNTER_WIDTH'(WAIT_TIME);

  logic                     sync1_q, sync1_d;
  logic                     sync2_q, sync2_d;
  logic                     cond_q,  cond_d;
  logic                     pos_q,   pos_d;
  logic                     neg_q,   neg_d;
  logic [COUNTER_WIDTH-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = pin_in;
    sync2_d = sync1_q;
    cond_d  = cond_q;
    cnt_d   = cnt_q;
    pos_d   = 1'b0;
    neg_d   = 1'b0;
    if (sync2_q == cond_q) begin
      cnt_d = '0;
    end else if (cnt_q == WAIT_CNT) begin
      // Stable for WAIT_TIME+1 evaluations: accept and pulse alongside the new level.
      cond_d = sync2_q;
      cnt_d  = '0;
      pos_d  = sync2_q;
      neg_d  = ~sync2_q;
    end else begin
      cnt_d = cnt_q + COUNTER_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      cond_q  <= RST_VAL;
      cnt_q   <= '0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cond_q  <= cond_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
    end
  end

  assign cond = cond_q;
  assign pos  = pos_q;
  assign neg  = neg_q;
endmodule

module spi_input_conditioner #(
  parameter int               WIDTH         = 3,
  parameter int               WAIT_TIME     = 3,
  parameter int               COUNTER_WIDTH = 3,
  parameter logic [WIDTH-1:0] RESET_VAL     = 3'b010
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_input_conditioner_if.slave bus
);
  logic [WIDTH-1:0] cond_w, pos_w, neg_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    spi_ic_lane #(
      .WAIT_TIME     (WAIT_TIME),
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .RST_VAL       (RESET_VAL[i])
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_in (bus.pins_in[i]),
      .cond   (cond_w[i]),
      .pos    (pos_w[i]),
      .neg    (neg_w[i])
    );
  end

  assign bus.conditioned = cond_w;
  assign bus.pos_edge    = pos_w;
  assign bus.neg_edge    = neg_w;
endmodule

// File: tb/tb_spi_input_conditioner.sv
// Bench for spi_input_conditioner: constant vector table, reset corner sequences
// and a random phase checked every cycle against a sample-window reference model.
module tb_spi_input_conditioner;
  localparam int         W   = 3;
  localparam int         WT  = 3;
  localparam int         CW  = 3;
  localparam logic [2:0] RV  = 3'b010;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  spi_input_conditioner_if #(.WIDTH(W)) bus ();

  spi_input_conditioner #(
    .WIDTH(W), .WAIT_TIME(WT), .COUNTER_WIDTH(CW), .RESET_VAL(RV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: a level is accepted once the last WT+1 synchronised samples all
  // disagree with the current conditioned level.
  logic [2:0] m_s1, m_s2, m_cond, m_pos, m_neg;
  logic [2:0] m_hist [WT+1];

  task automatic model_reset();
    m_s1 = RV; m_s2 = RV; m_cond = RV; m_pos = '0; m_neg = '0;
    for (int k = 0; k <= WT; k++) m_hist[k] = RV;
  endtask

  task automatic model_step(input logic [2:0] pins);
    bit all_diff;
    for (int k = WT; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = m_s2;
    m_pos = '0; m_neg = '0;
    for (int c = 0; c < W; c++) begin
      all_diff = 1'b1;
      for (int k = 0; k <= WT; k++) if (m_hist[k][c] == m_cond[c]) all_diff = 1'b0;
      if (all_diff) begin
        m_cond[c] = ~m_cond[c];
        if (m_cond[c]) m_pos[c] = 1'b1; else m_neg[c] = 1'b1;
      end
    end
    m_s2 = m_s1;
    m_s1 = pins;
  endtask

  task automatic cmp(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    cmp({tag, ".cond"}, bus.conditioned, m_cond);
    cmp({tag, ".pos"},  bus.pos_edge,    m_pos);
    cmp({tag, ".neg"},  bus.neg_edge,    m_neg);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_step(bus.pins_in);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    logic [2:0] pins;
    int         ticks;
    logic [2:0] cond;
    logic [2:0] pos;
    logic [2:0] neg;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{3'b010, 3, 3'b010, 3'b000, 3'b000};
    tbl[1]  = '{3'b011, 5, 3'b010, 3'b000, 3'b000};
    tbl[2]  = '{3'b011, 1, 3'b011, 3'b001, 3'b000};
    tbl[3]  = '{3'b011, 1, 3'b011, 3'b000, 3'b000};
    tbl[4]  = '{3'b010, 6, 3'b010, 3'b000, 3'b001};
    tbl[5]  = '{3'b011, 2, 3'b010, 3'b000, 3'b000};
    tbl[6]  = '{3'b010, 8, 3'b010, 3'b000, 3'b000};
    tbl[7]  = '{3'b101, 6, 3'b101, 3'b101, 3'b010};
    tbl[8]  = '{3'b101, 1, 3'b101, 3'b000, 3'b000};
    tbl[9]  = '{3'b010, 6, 3'b010, 3'b010, 3'b101};
    tbl[10] = '{3'b000, 3, 3'b010, 3'b000, 3'b000};
    tbl[11] = '{3'b010, 1, 3'b010, 3'b000, 3'b000};
    tbl[12] = '{3'b000, 5, 3'b010, 3'b000, 3'b000};
    tbl[13] = '{3'b000, 1, 3'b000, 3'b000, 3'b010};

    // Asynchronous reset with no clock edge, pins opposite to idle.
    rst_n = 1'b1;
    bus.pins_in = 3'b101;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    cmp("rst.cond", bus.conditioned, 3'b010);
    cmp("rst.pos",  bus.pos_edge,    3'b000);
    cmp("rst.neg",  bus.neg_edge,    3'b000);
    repeat (2) tick("rst_hold");
    bus.pins_in = RV;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      bus.pins_in = tbl[i].pins;
      repeat (tbl[i].ticks) tick($sformatf("vec%0d", i));
      cmp($sformatf("vec%0d.cond", i), bus.conditioned, tbl[i].cond);
      cmp($sformatf("vec%0d.pos", i),  bus.pos_edge,    tbl[i].pos);
      cmp($sformatf("vec%0d.neg", i),  bus.neg_edge,    tbl[i].neg);
    end

    // Reset mid-count during a MOSI rise: abort, then a single pulse after release.
    bus.pins_in = RV;
    repeat (8) tick("rmc_settle");
    cmp("rmc.settle", bus.conditioned, 3'b010);
    bus.pins_in = 3'b110;
    repeat (4) tick("rmc_count");
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    cmp("rmc.rst_cond", bus.conditioned, 3'b010);
    cmp("rmc.rst_pos",  bus.pos_edge,    3'b000);
    for (int i = 0; i < 3; i++) begin
      tick("rmc_hold");
      cmp("rmc.hold_pos", bus.pos_edge, 3'b000);
      cmp("rmc.hold_neg", bus.neg_edge, 3'b000);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick("rmc_rel");
      cmp("rmc.rel_pos", bus.pos_edge, 3'b000);
    end
    tick("rmc_pulse");
    cmp("rmc.pulse_pos",  bus.pos_edge,    3'b100);
    cmp("rmc.pulse_cond", bus.conditioned, 3'b110);
    tick("rmc_after");
    cmp("rmc.after_pos", bus.pos_edge, 3'b000);

    // Fast toggling on SCLK: no accepted change, level held.
    for (int i = 0; i < 20; i++) begin
      bus.pins_in = {2'b11, bus.pins_in[0] ^ 1'b1};
      repeat (1 + (i % 3)) tick("toggle");
      cmp("toggle.pos0", {2'b00, bus.pos_edge[0]}, 3'b000);
    end

    // Random phase against the reference model.
    for (int r = 0; r < 400; r++) begin
      bus.pins_in = 3'($urandom);
      repeat ($urandom_range(1, 8)) tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
